// File: rtl/sd_spi_ctrl.sv
// Byte-wide SPI master (mode 0) for the SD card, exposed to the CPU as a
// DATA / CTRL-STATUS register pair with optional auto-launch on DATA reads.
module sd_spi_ctrl #(
  parameter logic [2:0] DIV_RESET = 3'd7,
  parameter logic       IDLE_MOSI = 1'b1
) (
  input  logic       CLKX4,
  input  logic       RESET,
  input  logic       ADDR0,
  input  logic       WR_STB,
  input  logic       RD_STB,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SD_nCS,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        cs_r, cs_nxt_s;
  logic [2:0]  div_r, div_nxt_s;
  logic        auto_r, auto_nxt_s;
  logic        ovr_r, ovr_nxt_s;
  logic [7:0]  rxbuf_r, rxbuf_nxt_s;
  logic [7:0]  txsr_r, txsr_nxt_s;
  logic [7:0]  rxsr_r, rxsr_nxt_s;
  logic [2:0]  hcnt_r, hcnt_nxt_s;
  logic [2:0]  bcnt_r, bcnt_nxt_s;
  logic        sclk_r, mosi_r, busy_r, ncs_r;
  logic        sclk_nxt_s, mosi_nxt_s, busy_nxt_s;

  logic        data_wr_s, data_rd_auto_s, ctrl_wr_s, ctrl_rd_s;
  logic        idle_s, start_s, overrun_s;

  // Decode the CPU strobes into register events.
  always_comb begin
    data_wr_s      = WR_STB & ~ADDR0;
    data_rd_auto_s = RD_STB & ~ADDR0 & auto_r;
    ctrl_wr_s      = WR_STB & ADDR0;
    ctrl_rd_s      = RD_STB & ADDR0;
    idle_s         = (state_r == ST_IDLE);
    // The completion cycle is still non-IDLE, so a strobe there is an overrun.
    start_s        = idle_s & (data_wr_s | data_rd_auto_s);
    overrun_s      = ~idle_s & (data_wr_s | data_rd_auto_s);
  end

  // Transfer sequencer: next state, shift registers and counters.
  always_comb begin
    state_nxt_s = state_r;
    txsr_nxt_s  = txsr_r;
    rxsr_nxt_s  = rxsr_r;
    rxbuf_nxt_s = rxbuf_r;
    hcnt_nxt_s  = hcnt_r;
    bcnt_nxt_s  = bcnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_LOW;
          txsr_nxt_s  = data_wr_s ? DIN : 8'hFF;
          bcnt_nxt_s  = 3'd7;
          hcnt_nxt_s  = div_r;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (hcnt_r == 3'd0) begin
          state_nxt_s = ST_HIGH;
          hcnt_nxt_s  = div_r;
          rxsr_nxt_s  = {rxsr_r[6:0], MISO};
        end else begin
          hcnt_nxt_s  = hcnt_r - 3'd1;
        end
      end
      ST_HIGH: begin
        if (hcnt_r == 3'd0) begin
          if (bcnt_r == 3'd0) begin
            state_nxt_s = ST_IDLE;
            rxbuf_nxt_s = rxsr_r;
          end else begin
            state_nxt_s = ST_LOW;
            txsr_nxt_s  = {txsr_r[6:0], 1'b0};
            bcnt_nxt_s  = bcnt_r - 3'd1;
            hcnt_nxt_s  = div_r;
          end
        end else begin
          hcnt_nxt_s  = hcnt_r - 3'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Pin levels derived from the next state so the outputs leave flops directly.
  always_comb begin
    sclk_nxt_s = (state_nxt_s == ST_HIGH);
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    if (state_nxt_s == ST_IDLE) begin
      mosi_nxt_s = IDLE_MOSI;
    end else begin
      mosi_nxt_s = txsr_nxt_s[7];
    end
  end

  // Control register writes and the sticky overrun flag.
  always_comb begin
    cs_nxt_s   = cs_r;
    div_nxt_s  = div_r;
    auto_nxt_s = auto_r;
    if (ctrl_wr_s) begin
      cs_nxt_s   = DIN[0];
      div_nxt_s  = DIN[3:1];
      auto_nxt_s = DIN[5];
    end else begin
      cs_nxt_s   = cs_r;
    end
    if (overrun_s) begin
      ovr_nxt_s = 1'b1;
    end else if (ctrl_rd_s) begin
      ovr_nxt_s = 1'b0;
    end else begin
      ovr_nxt_s = ovr_r;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLKX4) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      cs_r    <= 1'b0;
      div_r   <= DIV_RESET;
      auto_r  <= 1'b0;
      ovr_r   <= 1'b0;
      rxbuf_r <= 8'hFF;
      txsr_r  <= 8'hFF;
      rxsr_r  <= 8'hFF;
      hcnt_r  <= 3'd0;
      bcnt_r  <= 3'd0;
      sclk_r  <= 1'b0;
      mosi_r  <= IDLE_MOSI;
      busy_r  <= 1'b0;
      ncs_r   <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cs_r    <= cs_nxt_s;
      div_r   <= div_nxt_s;
      auto_r  <= auto_nxt_s;
      ovr_r   <= ovr_nxt_s;
      rxbuf_r <= rxbuf_nxt_s;
      txsr_r  <= txsr_nxt_s;
      rxsr_r  <= rxsr_nxt_s;
      hcnt_r  <= hcnt_nxt_s;
      bcnt_r  <= bcnt_nxt_s;
      sclk_r  <= sclk_nxt_s;
      mosi_r  <= mosi_nxt_s;
      busy_r  <= busy_nxt_s;
      ncs_r   <= ~cs_nxt_s;
    end
  end

  // CPU read mux; a DATA read returns the buffer as it stood before any launch.
  always_comb begin
    if (ADDR0) begin
      DOUT = {busy_r, ovr_r, auto_r, 1'b0, div_r, cs_r};
    end else begin
      DOUT = rxbuf_r;
    end
  end

  assign SCLK   = sclk_r;
  assign MOSI   = mosi_r;
  assign BUSY   = busy_r;
  assign SD_nCS = ncs_r;

endmodule

// File: tb/tb_sd_spi_ctrl.sv
// Self-checking bench for sd_spi_ctrl: directed scenarios plus randomized
// transfers compared against a byte-level model of an SPI mode-0 exchange.
module tb_sd_spi_ctrl;

  logic       CLKX4, RESET, ADDR0, WR_STB, RD_STB, MISO;
  logic [7:0] DIN, DOUT;
  logic       SCLK, MOSI, SD_nCS, BUSY;

  int n_run  = 0;
  int n_fail = 0;

  // measurements of the last transfer
  int         m_busy_cycles, m_pulses, m_first_rise, m_period_err;
  int         m_mosi_glitch, m_end_cycle;
  logic [7:0] m_mosi, m_rx_at_end, m_dout_at_strobe;

  sd_spi_ctrl #(.DIV_RESET(3'd7), .IDLE_MOSI(1'b1)) dut (
    .CLKX4(CLKX4), .RESET(RESET), .ADDR0(ADDR0), .WR_STB(WR_STB),
    .RD_STB(RD_STB), .DIN(DIN), .DOUT(DOUT), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .SD_nCS(SD_nCS), .BUSY(BUSY)
  );

  initial CLKX4 = 1'b0;
  always #5 CLKX4 = ~CLKX4;

  task automatic wr_ctrl(input logic [7:0] v);
    @(negedge CLKX4);
    ADDR0 = 1'b1; DIN = v; WR_STB = 1'b1;
    @(negedge CLKX4);
    WR_STB = 1'b0; ADDR0 = 1'b0;
  endtask

  // Launch one byte (write, or auto read) and record what the pins do.
  // The card shifts out 'card' MSB first, changing after each SCLK fall.
  task automatic xfer(input bit use_read, input logic [7:0] tx, input logic [7:0] card,
                      input bit loopback, input int inj_cycle, input int h);
    int c, bitn, last_rise;
    bit done, prev_sclk, prev_mosi, fall;
    m_busy_cycles = 0; m_pulses = 0; m_first_rise = -1; m_period_err = 0;
    m_mosi_glitch = 0; m_end_cycle = -1; m_mosi = 8'h00; m_rx_at_end = 8'h00;
    last_rise = 0; bitn = 7;
    @(negedge CLKX4);
    ADDR0 = 1'b0; DIN = tx; WR_STB = !use_read; RD_STB = use_read;
    MISO = loopback ? MOSI : card[7];
    #1 m_dout_at_strobe = DOUT;
    @(negedge CLKX4);
    WR_STB = 1'b0; RD_STB = 1'b0;
    prev_sclk = SCLK; prev_mosi = MOSI;
    c = 1; done = 1'b0;
    while (!done && c < 400) begin
      if (c > 1) @(negedge CLKX4);
      WR_STB = (c == inj_cycle);
      if (c == inj_cycle) DIN = 8'h00;
      if (BUSY) m_busy_cycles++;
      fall = !SCLK && prev_sclk;
      if (SCLK && !prev_sclk) begin
        m_mosi = {m_mosi[6:0], MOSI};
        if (m_pulses == 0) m_first_rise = c;
        else if (c - last_rise != 2 * h) m_period_err++;
        last_rise = c;
        m_pulses++;
      end
      if (fall) begin
        bitn--;
        if (!loopback && bitn >= 0) MISO = card[bitn];
      end
      if (c > 1 && MOSI !== prev_mosi && !fall) m_mosi_glitch++;
      if (loopback) MISO = MOSI;
      prev_sclk = SCLK; prev_mosi = MOSI;
      if (!BUSY) begin
        m_end_cycle = c;
        m_rx_at_end = DOUT;
        done = 1'b1;
      end
      c++;
    end
    WR_STB = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLKX4);
    RESET = 1'b0;
    @(negedge CLKX4);
    n_run++; if (SD_nCS !== 1'b1) begin n_fail++; $display("FAIL reset_ncs got %b want 1", SD_nCS); end
    n_run++; if (SCLK !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got %b want 0", SCLK); end
    n_run++; if (MOSI !== 1'b1) begin n_fail++; $display("FAIL reset_mosi got %b want 1", MOSI); end
    n_run++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", BUSY); end
    ADDR0 = 1'b1; #1;
    n_run++; if (DOUT !== 8'h0E) begin n_fail++; $display("FAIL reset_ctrl got %h want 0e", DOUT); end
    ADDR0 = 1'b0; #1;
    n_run++; if (DOUT !== 8'hFF) begin n_fail++; $display("FAIL reset_rxbuf got %h want ff", DOUT); end
  endtask

  task automatic test_loopback();
    wr_ctrl(8'h01);
    n_run++; if (SD_nCS !== 1'b0) begin n_fail++; $display("FAIL loop_ncs got %b want 0", SD_nCS); end
    xfer(1'b0, 8'hA5, 8'h00, 1'b1, -1, 1);
    n_run++; if (m_pulses !== 8) begin n_fail++; $display("FAIL loop_pulses got %0d want 8", m_pulses); end
    n_run++; if (m_period_err !== 0 || m_first_rise !== 2) begin n_fail++; $display("FAIL loop_period err %0d first %0d want 0/2", m_period_err, m_first_rise); end
    n_run++; if (m_busy_cycles !== 16) begin n_fail++; $display("FAIL loop_busy got %0d want 16", m_busy_cycles); end
    n_run++; if (m_rx_at_end !== 8'hA5) begin n_fail++; $display("FAIL loop_rx got %h want a5", m_rx_at_end); end
    n_run++; if (m_mosi !== 8'hA5) begin n_fail++; $display("FAIL loop_mosi got %h want a5", m_mosi); end
  endtask

  task automatic test_slow_bit_order();
    wr_ctrl(8'h0F);
    xfer(1'b0, 8'h81, 8'h3C, 1'b0, -1, 8);
    n_run++; if (m_mosi !== 8'h81) begin n_fail++; $display("FAIL slow_mosi got %h want 81", m_mosi); end
    n_run++; if (m_first_rise !== 9 || m_period_err !== 0) begin n_fail++; $display("FAIL slow_cells first %0d err %0d want 9/0", m_first_rise, m_period_err); end
    n_run++; if (m_mosi_glitch !== 0) begin n_fail++; $display("FAIL slow_mosi_stable got %0d want 0", m_mosi_glitch); end
    n_run++; if (m_end_cycle !== 129) begin n_fail++; $display("FAIL slow_end got %0d want 129", m_end_cycle); end
    n_run++; if (m_rx_at_end !== 8'h3C) begin n_fail++; $display("FAIL slow_rx got %h want 3c", m_rx_at_end); end
  endtask

  task automatic test_overrun();
    logic [7:0] v;
    wr_ctrl(8'h01);
    xfer(1'b0, 8'h55, 8'h00, 1'b1, 5, 1);
    n_run++; if (m_mosi !== 8'h55) begin n_fail++; $display("FAIL ovr_mosi got %h want 55", m_mosi); end
    n_run++; if (m_rx_at_end !== 8'h55) begin n_fail++; $display("FAIL ovr_rx got %h want 55", m_rx_at_end); end
    @(negedge CLKX4);
    ADDR0 = 1'b1; #1 v = DOUT;
    n_run++; if (v[6] !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b want 1", v[6]); end
    RD_STB = 1'b1;
    @(negedge CLKX4);
    RD_STB = 1'b0; #1 v = DOUT;
    n_run++; if (v[6] !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", v[6]); end
    ADDR0 = 1'b0;
  endtask

  task automatic test_auto();
    wr_ctrl(8'h21);
    xfer(1'b1, 8'h00, 8'h12, 1'b0, -1, 1);
    n_run++; if (m_mosi !== 8'hFF) begin n_fail++; $display("FAIL auto1_mosi got %h want ff", m_mosi); end
    n_run++; if (m_rx_at_end !== 8'h12 || m_busy_cycles !== 16) begin n_fail++; $display("FAIL auto1_rx got %h/%0d want 12/16", m_rx_at_end, m_busy_cycles); end
    xfer(1'b1, 8'h00, 8'h34, 1'b0, -1, 1);
    n_run++; if (m_dout_at_strobe !== 8'h12) begin n_fail++; $display("FAIL auto2_old got %h want 12", m_dout_at_strobe); end
    n_run++; if (m_mosi !== 8'hFF || m_mosi_glitch !== 0) begin n_fail++; $display("FAIL auto2_mosi got %h/%0d want ff/0", m_mosi, m_mosi_glitch); end
    @(negedge CLKX4);
    ADDR0 = 1'b0; #1;
    n_run++; if (DOUT !== 8'h34) begin n_fail++; $display("FAIL auto_final got %h want 34", DOUT); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    wr_ctrl(8'h01);
    @(negedge CLKX4);
    ADDR0 = 1'b0; DIN = 8'hC3; WR_STB = 1'b1;
    @(negedge CLKX4);
    WR_STB = 1'b0;
    repeat (6) @(negedge CLKX4);
    n_run++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got %b want 1", BUSY); end
    RESET = 1'b1;
    @(negedge CLKX4);
    #1;
    n_run++; if ({SCLK, BUSY, SD_nCS, MOSI} !== 4'b0011) begin n_fail++; $display("FAIL mid_pins got %b want 0011", {SCLK, BUSY, SD_nCS, MOSI}); end
    n_run++; if (DOUT !== 8'hFF) begin n_fail++; $display("FAIL mid_rxbuf got %h want ff", DOUT); end
    RESET = 1'b0;
    wr_ctrl(8'h01);
    b = 8'($urandom);
    xfer(1'b0, b, 8'h00, 1'b1, -1, 1);
    n_run++; if (m_rx_at_end !== b || m_mosi !== b) begin n_fail++; $display("FAIL mid_after got %h/%h want %h", m_rx_at_end, m_mosi, b); end
  endtask

  task automatic test_random();
    int div, h;
    bit cs, rd;
    logic [7:0] tx, card, ctrl;
    for (int i = 0; i < 12; i++) begin
      div = $urandom_range(0, 7);
      h = div + 1;
      cs = 1'($urandom);
      rd = 1'($urandom);
      tx = 8'($urandom);
      card = 8'($urandom);
      ctrl = {2'b00, rd, 1'b0, 3'(div), cs};
      wr_ctrl(ctrl);
      @(negedge CLKX4);
      ADDR0 = 1'b1; #1;
      n_run++; if (DOUT !== ctrl) begin n_fail++; $display("FAIL rnd_ctrl[%0d] got %h want %h", i, DOUT, ctrl); end
      ADDR0 = 1'b0;
      n_run++; if (SD_nCS !== !cs) begin n_fail++; $display("FAIL rnd_ncs[%0d] got %b want %b", i, SD_nCS, !cs); end
      xfer(rd, tx, card, 1'b0, -1, h);
      n_run++; if (m_mosi !== (rd ? 8'hFF : tx)) begin n_fail++; $display("FAIL rnd_mosi[%0d] got %h want %h", i, m_mosi, rd ? 8'hFF : tx); end
      n_run++; if (m_rx_at_end !== card) begin n_fail++; $display("FAIL rnd_rx[%0d] got %h want %h", i, m_rx_at_end, card); end
      n_run++; if (m_busy_cycles !== 16 * h || m_end_cycle !== 1 + 16 * h) begin n_fail++; $display("FAIL rnd_timing[%0d] got %0d/%0d want %0d/%0d", i, m_busy_cycles, m_end_cycle, 16 * h, 1 + 16 * h); end
      n_run++; if (m_pulses !== 8 || m_period_err !== 0 || m_first_rise !== 1 + h) begin n_fail++; $display("FAIL rnd_sclk[%0d] got %0d/%0d/%0d want 8/0/%0d", i, m_pulses, m_period_err, m_first_rise, 1 + h); end
    end
  endtask

  initial begin
    RESET = 1'b1; ADDR0 = 1'b0; WR_STB = 1'b0; RD_STB = 1'b0; DIN = 8'h00; MISO = 1'b1;
    test_reset();
    test_loopback();
    test_slow_bit_order();
    test_overrun();
    test_auto();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
